// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the run/idle state encoding and the divisor clamp rule.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } divState_t;

    localparam int unsigned MIN_DIV = 2;

    // Ratios below two cannot form a high and a low phase, so they are raised to two.
    function automatic int unsigned clampDiv(input int unsigned divReq);
        return (divReq < MIN_DIV) ? MIN_DIV : divReq;
    endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a registered output clock and period tick.
// Ratio changes and stop requests only land on period boundaries, so clk_o never glitches.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_o,
    output logic             tick,
    output logic [CNT_W-1:0] div_o,
    output logic             running
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    divState_t        r_state,   w_stateNxt;
    logic [CNT_W-1:0] r_cnt,     w_cntNxt;
    logic [CNT_W-1:0] r_divCur,  w_divCurNxt;
    logic [CNT_W-1:0] r_pend,    w_pendNxt;
    logic             r_pendVld, w_pendVldNxt;
    logic             r_clkO,    w_clkONxt;
    logic             r_tick,    w_tickNxt;
    logic             r_running, w_runningNxt;

    logic [CNT_W-1:0] w_divClamped;
    logic [CNT_W-1:0] w_high;
    logic [CNT_W-1:0] w_cntInc;
    logic             w_wrap;
    logic             w_start;

    assign w_divClamped = CNT_W'(clampDiv(32'(div_in)));
    // High time is ceil(N/2); split into halves so N = 2^CNT_W-1 cannot overflow.
    assign w_high   = (r_divCur >> 1) + {{(CNT_W-1){1'b0}}, r_divCur[0]};
    assign w_cntInc = r_cnt + ONE;
    assign w_wrap   = (r_cnt == (r_divCur - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_divCur  <= DEF_DIV;
            r_pend    <= DEF_DIV;
            r_pendVld <= 1'b0;
            r_clkO    <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_stateNxt;
            r_cnt     <= w_cntNxt;
            r_divCur  <= w_divCurNxt;
            r_pend    <= w_pendNxt;
            r_pendVld <= w_pendVldNxt;
            r_clkO    <= w_clkONxt;
            r_tick    <= w_tickNxt;
            r_running <= w_runningNxt;
        end
    end

    always_comb begin
        w_stateNxt   = r_state;
        w_cntNxt     = r_cnt;
        w_divCurNxt  = r_divCur;
        w_pendNxt    = r_pend;
        w_pendVldNxt = r_pendVld;
        w_clkONxt    = r_clkO;
        w_tickNxt    = 1'b0;
        w_runningNxt = r_running;
        w_start      = 1'b0;

        case (r_state)
            RUN: begin
                if (w_wrap) begin
                    if (en) begin
                        w_start = 1'b1;
                    end else begin
                        w_stateNxt   = IDLE;
                        w_cntNxt     = '0;
                        w_clkONxt    = 1'b0;
                        w_runningNxt = 1'b0;
                    end
                end else begin
                    w_cntNxt  = w_cntInc;
                    w_clkONxt = (w_cntInc < w_high);
                end
            end
            default: begin
                w_cntNxt     = '0;
                w_clkONxt    = 1'b0;
                w_runningNxt = 1'b0;
                w_start      = en;
            end
        endcase

        // A load arriving on the start edge skips the pending slot and sizes this very period.
        if (w_start) begin
            w_stateNxt   = RUN;
            w_cntNxt     = '0;
            w_clkONxt    = 1'b1;
            w_tickNxt    = 1'b1;
            w_runningNxt = 1'b1;
            if (div_load) begin
                w_divCurNxt  = w_divClamped;
                w_pendVldNxt = 1'b0;
            end else if (r_pendVld) begin
                w_divCurNxt  = r_pend;
                w_pendVldNxt = 1'b0;
            end
        end else if (div_load) begin
            w_pendNxt    = w_divClamped;
            w_pendVldNxt = 1'b1;
        end
    end

    assign clk_o   = r_clkO;
    assign tick    = r_tick;
    assign running = r_running;
    assign div_o   = r_pendVld ? r_pend : r_divCur;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomised self-checking bench for clk_div_prog against a period-waveform reference model.
// The model queues the whole expected waveform of each period when it starts and replays it.
module tb_clk_div_prog;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             clk_o;
    logic             tick;
    logic [CNT_W-1:0] div_o;
    logic             running;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state: remaining samples of the current period as {clk_o, tick}.
    bit [1:0] mQ[$];
    int       mClk, mTick, mRun, mCur, mPend, mPendV;

    clk_div_prog #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_in  (div_in),
        .div_load(div_load),
        .clk_o   (clk_o),
        .tick    (tick),
        .div_o   (div_o),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
        end
    endtask

    function automatic int clampRef(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic modelReset();
        mQ.delete();
        mClk   = 0;
        mTick  = 0;
        mRun   = 0;
        mCur   = DEFAULT_DIV;
        mPend  = DEFAULT_DIV;
        mPendV = 0;
    endtask

    task automatic modelStep(input int e, input int ld, input int d);
        bit [1:0] s;
        if (mQ.size() == 0) begin
            if (e != 0) begin
                if (ld != 0) begin
                    mCur   = clampRef(d);
                    mPendV = 0;
                end else if (mPendV != 0) begin
                    mCur   = mPend;
                    mPendV = 0;
                end
                for (int i = 0; i < mCur; i++)
                    mQ.push_back({(i < (mCur + 1) / 2) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
                s     = mQ.pop_front();
                mClk  = s[1];
                mTick = s[0];
                mRun  = 1;
            end else begin
                mClk  = 0;
                mTick = 0;
                mRun  = 0;
                if (ld != 0) begin
                    mPend  = clampRef(d);
                    mPendV = 1;
                end
            end
        end else begin
            s     = mQ.pop_front();
            mClk  = s[1];
            mTick = s[0];
            mRun  = 1;
            if (ld != 0) begin
                mPend  = clampRef(d);
                mPendV = 1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("clk_o",   int'(clk_o),   mClk);
        checkOutput("tick",    int'(tick),    mTick);
        checkOutput("running", int'(running), mRun);
        checkOutput("div_o",   int'(div_o),   (mPendV != 0) ? mPend : mCur);
    endtask

    // Drive one cycle of inputs just after a falling edge, advance the model, check at the next falling edge.
    task automatic applyStimulus(input int e, input int ld, input int d);
        en       = (e != 0);
        div_load = (ld != 0);
        div_in   = CNT_W'(d);
        modelStep(e, ld, d);
        @(negedge clk);
        cycle++;
        checkAll();
    endtask

    task automatic runUntilStart(input int n, input string tag);
        int guard;
        guard = 0;
        while (!(mTick == 1 && mCur == n) && guard < 600) begin
            applyStimulus(1, 0, 0);
            guard++;
        end
        if (guard >= 600) checkOutput(tag, 0, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        rst_n = 1'b1;
        @(negedge clk);
        checkAll();

        // Default ratio of four
        for (int i = 0; i < 13; i++) applyStimulus(1, 0, 0);

        // Load five mid-period
        applyStimulus(1, 1, 5);
        for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0);

        // Ratios 0 and 1 clamp to 2
        applyStimulus(1, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0);

        // Stop request early in an N=6 period
        applyStimulus(1, 1, 6);
        runUntilStart(6, "wait_n6");
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0);

        // Largest ratio: 128 high, 127 low
        applyStimulus(0, 1, 255);
        for (int i = 0; i < 520; i++) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 8);
        runUntilStart(8, "wait_n8");

        // Asynchronous reset while clk_o is high at cnt=2
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        checkAll();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int e, ld, d;
            e  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            ld = ($urandom_range(0, 19) == 0) ? 1 : 0;
            d  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            applyStimulus(e, ld, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider. It is the parametrised successor of the fixed divide-by-4 block. It produces a registered divided clock `clk_o` for any ratio N from 2 to 2^CNT_W-1, plus a one-cycle `tick` strobe at the start of each output period. Ratio changes and stop requests take effect only at period boundaries, so `clk_o` never shows runt pulses. It sits beside the fixed dividers and feeds slow-domain enables and debug clock outputs.

Parameters:
- CNT_W, 8: width of the divisor and internal counter.
- DEFAULT_DIV, 4: divisor after reset. Must be ≥2 and ≤2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request; sampled every cycle.
- div_in  input  CNT_W  new divisor value.
- div_load  input  1  one-cycle strobe; captures div_in.
- clk_o  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse, coincident with each clk_o rising edge.
- div_o  output  CNT_W  divisor of the current/next period.
- running  output  1  high while in RUN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, clk_o=0, tick=0, running=0, div_cur=DEFAULT_DIV, pend_vld=0, div_o=DEFAULT_DIV.
- Clamp: a captured div_in<2 is stored as 2. No other width arithmetic; cnt is CNT_W bits and never exceeds div_cur-1.
- H = (div_cur+1)>>1, i.e. the high time. Even N gives exactly 50% duty. Odd N gives high (N+1)/2 cycles, low (N-1)/2 cycles. Single-edge only; no negedge logic.
- div_load:
  - pend <= clamp(div_in), pend_vld<=1. Last load before a boundary wins.
  - div_o reflects pend when pend_vld=1, else div_cur.
- State IDLE:
  - clk_o=0, tick=0, running=0.
  - On edge with en=1: cnt<=0, clk_o<=1, tick<=1, running<=1, state<=RUN, and div_cur<=pend if pend_vld (pend_vld<=0).
  - Latency from en sampled high to clk_o high is 1 clk.
- State RUN, non-wrap (cnt≠div_cur-1): cnt<=cnt+1, clk_o<=(cnt+1<H), tick<=0.
- State RUN, wrap (cnt==div_cur-1):
  - en=1: cnt<=0, clk_o<=1, tick<=1, apply pend as in IDLE.
  - en=0: cnt<=0, clk_o<=0, tick<=0, running<=0, state<=IDLE.
- en deasserted mid-period: the current period always completes in full. Output is never truncated.
- div_load on the wrap/start cycle: the new value bypasses pend and applies to the period starting that edge.
- en toggling mid-period has no effect. Only its value at the wrap edge matters.
- rst_n asserted mid-period: clk_o drops to 0 immediately (async). This is the only permitted runt.
- tick is registered, never combinational from inputs.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN}
  - localparam MIN_DIV=2
  - clamp function for the divisor
- No sub-module. The pending-ratio register is too small to split out; a single module of roughly 150 lines is the intent.

Test Plan:
- Reset, then en=1 with default N=4 → clk_o 1,1,0,0 repeating; tick high every 4th cycle aligned with clk_o rise; running=1 one cycle after en.
- div_load div_in=5 mid-period of N=4 → current period finishes as 4 cycles; next periods are high 3 / low 2; div_o=5 immediately after load.
- div_in=0 and div_in=1 loaded → both clamp to N=2; clk_o toggles every cycle; div_o=2.
- en dropped at cnt=1 of an N=6 period → clk_o holds 1,1,1,0,0,0 to completion, then 0; running falls at the wrap edge; no tick afterwards.
- N=255 (CNT_W=8) → high 128, low 127; cnt wraps 254→0 with no overflow.
- rst_n asserted at cnt=2 of N=8 → clk_o=0, tick=0 with no clk edge needed; after release, div_o=DEFAULT_DIV and state IDLE.
